// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: main control for the 5-stage MIPS core.
// Decodes the ID opcode into a control bundle and carries it through the
// EX, MEM and WB stage registers. Load-use hazards raise a stall. Stall,
// flush and illegal opcodes insert a bubble into EX.
module ctrl_pipe_unit #(
   parameter int REG_ADDR_W = 5,
   parameter bit EXT_OPS    = 1'b1,
   parameter int ALUOP_W    = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  logic [5:0]            op_i,
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rt_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   output logic                  stall_o,
   output logic                  id_branch_o,
   output logic                  id_jump_o,
   output logic                  ex_alu_src_o,
   output logic                  ex_ext_op_o,
   output logic [ALUOP_W-1:0]    ex_alu_op_o,
   output logic [REG_ADDR_W-1:0] ex_wreg_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic                  wb_reg_write_o,
   output logic                  wb_mem_to_reg_o,
   output logic [REG_ADDR_W-1:0] wb_wreg_o,
   output logic                  illegal_o
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b100);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b101);

   // Control bundle held in the EX stage register; an all-zero value is a bubble.
   typedef struct packed {
      logic                  valid;
      logic                  alu_src;
      logic                  ext_op;
      logic [ALUOP_W-1:0]    alu_op;
      logic [REG_ADDR_W-1:0] wreg;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
      logic                  mem_to_reg;
   } ctrl_t;

   ctrl_t                 w_dec;
   logic                  w_uses_rs;
   logic                  w_uses_rt;
   logic                  w_is_branch;
   logic                  w_is_jump;
   logic                  w_illegal;
   logic                  w_hazard;
   logic                  w_stall;
   logic                  w_accept;

   ctrl_t                 r_ex;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic                  r_mem_reg_write;
   logic                  r_mem_mem_to_reg;
   logic [REG_ADDR_W-1:0] r_mem_wreg;
   logic                  r_wb_reg_write;
   logic                  r_wb_mem_to_reg;
   logic [REG_ADDR_W-1:0] r_wb_wreg;
   logic                  r_illegal;

   // Opcode decode into a control bundle plus register-usage flags.
   always_comb begin
      w_dec       = '0;
      w_uses_rs   = 1'b1;
      w_uses_rt   = 1'b0;
      w_is_branch = 1'b0;
      w_is_jump   = 1'b0;
      w_illegal   = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            w_dec.valid     = 1'b1;
            w_dec.wreg      = rd_i;
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = ALU_FUNCT;
            w_uses_rt       = 1'b1;
         end
         OP_ADDI, OP_LW: begin
            w_dec.valid      = 1'b1;
            w_dec.wreg       = rt_i;
            w_dec.alu_src    = 1'b1;
            w_dec.ext_op     = 1'b1;
            w_dec.alu_op     = ALU_ADD;
            w_dec.reg_write  = 1'b1;
            w_dec.mem_read   = (op_i == OP_LW);
            w_dec.mem_to_reg = (op_i == OP_LW);
         end
         OP_SW: begin
            w_dec.valid     = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.ext_op    = 1'b1;
            w_dec.alu_op    = ALU_ADD;
            w_dec.mem_write = 1'b1;
            w_uses_rt       = 1'b1;
         end
         OP_BEQ: begin
            w_dec.valid = 1'b1;
            w_dec.alu_op = ALU_SUB;
            w_uses_rt   = 1'b1;
            w_is_branch = 1'b1;
         end
         OP_J: begin
            // Jump is resolved in ID; nothing useful travels down the pipe.
            w_is_jump = 1'b1;
            w_uses_rs = 1'b0;
         end
         OP_ANDI, OP_ORI: begin
            if (EXT_OPS) begin
               w_dec.valid     = 1'b1;
               w_dec.wreg      = rt_i;
               w_dec.alu_src   = 1'b1;
               w_dec.ext_op    = 1'b0;
               w_dec.alu_op    = (op_i == OP_ORI) ? ALU_OR : ALU_AND;
               w_dec.reg_write = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase
      // Writes to $0 are discarded at the source.
      if (w_dec.wreg == '0) begin
         w_dec.reg_write = 1'b0;
      end
   end

   // Load-use hazard against the instruction currently in EX.
   always_comb begin
      w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.wreg != '0) &&
                 ((w_uses_rs && (r_ex.wreg == rs_i)) ||
                  (w_uses_rt && (r_ex.wreg == rt_i)));
      w_stall  = valid_i && !flush_i && w_hazard;
      w_accept = valid_i && !flush_i && !w_stall;
   end

   assign stall_o     = w_stall;
   assign id_branch_o = w_accept && w_is_branch;
   assign id_jump_o   = w_accept && w_is_jump;

   // Stage registers: EX takes the decode or a bubble; MEM and WB always advance.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_ex             <= '0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_wreg       <= '0;
         r_wb_reg_write   <= 1'b0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_wreg        <= '0;
         r_illegal        <= 1'b0;
      end else begin
         r_ex             <= (w_accept && !w_illegal) ? w_dec : '0;
         r_mem_read       <= r_ex.mem_read;
         r_mem_write      <= r_ex.mem_write;
         r_mem_reg_write  <= r_ex.reg_write;
         r_mem_mem_to_reg <= r_ex.mem_to_reg;
         r_mem_wreg       <= r_ex.wreg;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_wreg        <= r_mem_wreg;
         r_illegal        <= w_accept && w_illegal;
      end
   end

   assign ex_alu_src_o    = r_ex.alu_src;
   assign ex_ext_op_o     = r_ex.ext_op;
   assign ex_alu_op_o     = r_ex.alu_op;
   assign ex_wreg_o       = r_ex.wreg;
   assign mem_read_o      = r_mem_read;
   assign mem_write_o     = r_mem_write;
   assign wb_reg_write_o  = r_wb_reg_write;
   assign wb_mem_to_reg_o = r_wb_mem_to_reg;
   assign wb_wreg_o       = r_wb_wreg;
   assign illegal_o       = r_illegal;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: two instances (extended ops on and off) share
// stimulus; each is compared against a transaction-level pipeline model.
module tb_ctrl_pipe_unit;

   localparam bit [5:0] RT   = 6'b000000;
   localparam bit [5:0] ADDI = 6'b001000;
   localparam bit [5:0] LW   = 6'b100011;
   localparam bit [5:0] SW   = 6'b101011;
   localparam bit [5:0] BEQ  = 6'b000100;
   localparam bit [5:0] J    = 6'b000010;
   localparam bit [5:0] ANDI = 6'b001100;
   localparam bit [5:0] ORI  = 6'b001101;

   typedef struct packed {
      bit       v;
      bit       src;
      bit       ext;
      bit [2:0] aop;
      bit [4:0] wreg;
      bit       mr;
      bit       mw;
      bit       rw;
      bit       m2r;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       valid;
   logic       flush;
   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;

   logic [1:0] stall_w, branch_w, jump_w, src_w, ext_w, mr_w, mw_w, rw_w, m2r_w, ill_w;
   logic [2:0] aop_w  [2];
   logic [4:0] exw_w  [2];
   logic [4:0] wbw_w  [2];

   int   n_cmp;
   int   n_err;
   int   n_step;
   bit   model_ok;
   logic [1:0] last_stall;
   logic [1:0] last_branch;

   exp_t m_ex  [2];
   exp_t m_mem [2];
   exp_t m_wb  [2];
   bit   m_ill [2];

   ctrl_pipe_unit #(.REG_ADDR_W(5), .EXT_OPS(1'b1), .ALUOP_W(3)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
      .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd),
      .stall_o(stall_w[1]), .id_branch_o(branch_w[1]), .id_jump_o(jump_w[1]),
      .ex_alu_src_o(src_w[1]), .ex_ext_op_o(ext_w[1]), .ex_alu_op_o(aop_w[1]),
      .ex_wreg_o(exw_w[1]), .mem_read_o(mr_w[1]), .mem_write_o(mw_w[1]),
      .wb_reg_write_o(rw_w[1]), .wb_mem_to_reg_o(m2r_w[1]), .wb_wreg_o(wbw_w[1]),
      .illegal_o(ill_w[1])
   );

   ctrl_pipe_unit #(.REG_ADDR_W(5), .EXT_OPS(1'b0), .ALUOP_W(3)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
      .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd),
      .stall_o(stall_w[0]), .id_branch_o(branch_w[0]), .id_jump_o(jump_w[0]),
      .ex_alu_src_o(src_w[0]), .ex_ext_op_o(ext_w[0]), .ex_alu_op_o(aop_w[0]),
      .ex_wreg_o(exw_w[0]), .mem_read_o(mr_w[0]), .mem_write_o(mw_w[0]),
      .wb_reg_write_o(rw_w[0]), .wb_mem_to_reg_o(m2r_w[0]), .wb_wreg_o(wbw_w[0]),
      .illegal_o(ill_w[0])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (step %0d)", tag, obs, req, n_step);
      end
   endtask

   // What an instruction means, straight from the opcode table.
   function automatic exp_t ref_decode(int k, bit [5:0] o, bit [4:0] t, bit [4:0] d);
      exp_t e;
      e = '0;
      if (o == RT) begin
         e.v = 1; e.wreg = d; e.rw = 1; e.aop = 3'd3;
      end else if (o == ADDI || o == LW) begin
         e.v = 1; e.wreg = t; e.src = 1; e.ext = 1; e.aop = 3'd0; e.rw = 1;
         e.mr = (o == LW); e.m2r = (o == LW);
      end else if (o == SW) begin
         e.v = 1; e.src = 1; e.ext = 1; e.mw = 1;
      end else if (o == BEQ) begin
         e.v = 1; e.aop = 3'd1;
      end else if (k == 1 && (o == ANDI || o == ORI)) begin
         e.v = 1; e.wreg = t; e.src = 1; e.aop = (o == ORI) ? 3'd5 : 3'd4; e.rw = 1;
      end
      if (e.wreg == 0) e.rw = 0;
      return e;
   endfunction

   function automatic bit ref_legal(int k, bit [5:0] o);
      if (o == RT || o == ADDI || o == LW || o == SW || o == BEQ || o == J) return 1;
      if (k == 1 && (o == ANDI || o == ORI)) return 1;
      return 0;
   endfunction

   function automatic bit ref_stall(int k, bit v, bit f, bit [5:0] o, bit [4:0] s, bit [4:0] t);
      bit rs_hit, rt_hit;
      rs_hit = (o != J) && (m_ex[k].wreg == s);
      rt_hit = (o == RT || o == SW || o == BEQ) && (m_ex[k].wreg == t);
      return v && !f && m_ex[k].v && m_ex[k].mr && (m_ex[k].wreg != 0) && (rs_hit || rt_hit);
   endfunction

   // One clock: drive at negedge, check ID outputs, clock, check stage outputs.
   task automatic step(input bit r, input bit v, input bit f, input bit [5:0] o,
                       input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
      exp_t nex [2];
      bit   nill [2];
      bit   st, acc;
      rst = r; valid = v; flush = f; op = o; rs = s; rt = t; rd = d;
      #1;
      last_stall  = stall_w;
      last_branch = branch_w;
      for (int k = 0; k < 2; k++) begin
         st  = ref_stall(k, v, f, o, s, t);
         acc = v && !f && !st;
         if (model_ok) begin
            chk($sformatf("stall%0d", k), stall_w[k], st);
            chk($sformatf("branch%0d", k), branch_w[k], acc && o == BEQ);
            chk($sformatf("jump%0d", k), jump_w[k], acc && o == J);
         end
         if (!r) begin
            nex[k] = '0; nill[k] = 0;
         end else begin
            nex[k]  = (acc && ref_legal(k, o)) ? ref_decode(k, o, t, d) : '0;
            nill[k] = acc && !ref_legal(k, o);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            m_wb[k] = '0; m_mem[k] = '0;
         end else begin
            m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k];
         end
         m_ex[k]  = nex[k];
         m_ill[k] = nill[k];
      end
      if (!r) model_ok = 1;
      @(negedge clk);
      $display("step %0d rst=%0b v=%0b fl=%0b op=%b rs=%0d rt=%0d rd=%0d stall=%b ill=%b",
               n_step, r, v, f, o, s, t, d, last_stall, ill_w);
      if (model_ok) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("ex_alu_src%0d", k), src_w[k], m_ex[k].src);
            chk($sformatf("ex_ext_op%0d", k), ext_w[k], m_ex[k].ext);
            chk($sformatf("ex_alu_op%0d", k), aop_w[k], m_ex[k].aop);
            chk($sformatf("ex_wreg%0d", k), exw_w[k], m_ex[k].wreg);
            chk($sformatf("mem_read%0d", k), mr_w[k], m_mem[k].mr);
            chk($sformatf("mem_write%0d", k), mw_w[k], m_mem[k].mw);
            chk($sformatf("wb_reg_write%0d", k), rw_w[k], m_wb[k].rw);
            chk($sformatf("wb_mem_to_reg%0d", k), m2r_w[k], m_wb[k].m2r);
            chk($sformatf("wb_wreg%0d", k), wbw_w[k], m_wb[k].wreg);
            chk($sformatf("illegal%0d", k), ill_w[k], m_ill[k]);
         end
      end
      n_step++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, RT, 0, 0, 0);
   endtask

   initial begin
      bit [5:0] ops [9];
      bit [5:0] o;
      n_cmp = 0; n_err = 0; n_step = 0; model_ok = 0;
      rst = 0; valid = 0; flush = 0; op = '0; rs = '0; rt = '0; rd = '0;
      ops = '{RT, ADDI, LW, SW, BEQ, J, ANDI, ORI, 6'b111111};
      @(negedge clk);

      // Reset with a load presented: everything stays a bubble.
      step(0, 1, 0, LW, 1, 2, 3);
      step(0, 1, 0, LW, 1, 2, 3);
      chk("tp1_stall", last_stall[1], 0);
      chk("tp1_ex_alu_src", src_w[1], 0);

      // lw $2 then add $3,$2,$1: one stall, then the add proceeds.
      step(1, 1, 0, LW, 1, 2, 0);
      step(1, 1, 0, RT, 2, 1, 3);
      chk("tp2_stall", last_stall[1], 1);
      chk("tp2_bubble_wreg", exw_w[1], 0);
      step(1, 1, 0, RT, 2, 1, 3);
      chk("tp2_nostall", last_stall[1], 0);
      chk("tp2_add_aop", aop_w[1], 3);
      chk("tp2_add_wreg", exw_w[1], 3);
      chk("tp2_wb_m2r", m2r_w[1], 1);
      chk("tp2_wb_wreg", wbw_w[1], 2);
      idle(3);

      // lw $0 never causes a hazard and never writes.
      step(1, 1, 0, LW, 1, 0, 0);
      step(1, 1, 0, RT, 0, 0, 3);
      chk("tp3_stall", last_stall[1], 0);
      step(1, 0, 0, RT, 0, 0, 0);
      chk("tp3_wb_rw", rw_w[1], 0);
      idle(2);

      // ori $5: legal with extended ops, illegal without.
      step(1, 1, 0, ORI, 1, 5, 0);
      chk("tp4_ext", ext_w[1], 0);
      chk("tp4_aop", aop_w[1], 5);
      chk("tp4_ill0", ill_w[0], 1);
      idle(1);
      chk("tp4_ill0_pulse", ill_w[0], 0);
      idle(1);
      chk("tp4_wb_rw", rw_w[1], 1);
      chk("tp4_wb_wreg", wbw_w[1], 5);
      idle(2);

      // Flush beats a hazard on beq.
      step(1, 1, 0, LW, 1, 4, 0);
      step(1, 1, 1, BEQ, 4, 1, 0);
      chk("tp5_stall", last_stall[1], 0);
      chk("tp5_branch", last_branch[1], 0);
      idle(3);

      // sw uses rt: lw $7 then sw rt=7 stalls once.
      step(1, 1, 0, LW, 1, 7, 0);
      step(1, 1, 0, SW, 1, 7, 0);
      chk("tp6_stall", last_stall[1], 1);
      step(1, 1, 0, SW, 1, 7, 0);
      idle(1);
      chk("tp6_mem_write", mw_w[1], 1);
      idle(1);
      chk("tp6_wb_rw", rw_w[1], 0);
      idle(2);

      // Random traffic over a small register set to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         o = ops[$urandom_range(0, 8)];
         if (o == 6'b111111) o = 6'($urandom);
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 7) == 0), o,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Next-generation main control for the 5-stage MIPS core.
- Decodes the ID-stage opcode into a control bundle, then carries that bundle through EX, MEM and WB pipeline registers.
- Detects load-use hazards and raises a stall; inserts bubbles on stall, flush or illegal opcode.
- Optional extended-op mode adds andi/ori decode.
- Sits between the IF/ID register and the datapath stage muxes; replaces per-stage control latches in the top level.

Parameters:
REG_ADDR_W, 5, register-index width for rs/rt/rd and destination fields
EXT_OPS, 1, 1 = decode andi (001100) and ori (001101); 0 = treat them as illegal
ALUOP_W, 3, ALUOp width; must be >= 3

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-low reset
valid_i  in  1  IF/ID holds a real instruction
flush_i  in  1  squash the current ID instruction (taken branch/jump)
op_i  in  6  opcode of ID instruction
rs_i  in  REG_ADDR_W  rs field
rt_i  in  REG_ADDR_W  rt field
rd_i  in  REG_ADDR_W  rd field
stall_o  out  1  load-use hazard: hold PC and IF/ID this cycle (combinational)
id_branch_o  out  1  beq in ID, not stalled or flushed (combinational)
id_jump_o  out  1  j in ID, not stalled or flushed (combinational)
ex_alu_src_o  out  1  EX: immediate operand
ex_ext_op_o  out  1  EX: 1 = sign-extend, 0 = zero-extend immediate
ex_alu_op_o  out  ALUOP_W  EX: 000 add, 001 sub, 011 funct-decoded, 100 and, 101 or
ex_wreg_o  out  REG_ADDR_W  EX destination register
mem_read_o  out  1  MEM: load
mem_write_o  out  1  MEM: store
wb_reg_write_o  out  1  WB: write register file
wb_mem_to_reg_o  out  1  WB: select memory data
wb_wreg_o  out  REG_ADDR_W  WB destination register
illegal_o  out  1  registered one-cycle pulse: unrecognised opcode was accepted

Behaviour:
- Reset (rst_i low at a clock edge): every stage register is cleared to a bubble (all fields 0, valid 0), and illegal_o is 0.
  - All registered outputs read 0 in the cycle after reset.
  - Reset overrides stall and flush.
- Decode, Rtype (000000):
  - Destination = rd; reg_write = 1; ALUOp = 011.
  - Uses rs and rt.
- Decode, addi (001000):
  - Destination = rt; alu_src = 1; ext = 1; ALUOp = 000; reg_write = 1.
- Decode, lw (100011):
  - Same as addi, plus mem_read = 1 and mem_to_reg = 1.
- Decode, sw (101011):
  - alu_src = 1; ext = 1; ALUOp = 000; mem_write = 1.
  - Uses rt; destination = 0.
- Decode, beq (000100):
  - ALUOp = 001; uses rt; id_branch_o.
- Decode, j (000010):
  - id_jump_o only; the bubble continues down the pipe.
- Decode, andi/ori (EXT_OPS = 1 only):
  - Destination = rt; alu_src = 1; ext = 0; ALUOp = 100 (andi) or 101 (ori); reg_write = 1.
- Any other opcode with valid_i = 1, and no stall or flush:
  - A bubble is sent into EX.
  - illegal_o = 1 on the next cycle.
- Destination register 0 forces reg_write = 0 at decode.
- Hazard rule: stall_o = valid_i & !flush_i & EX.valid & EX.mem_read & EX.wreg != 0 & (EX.wreg == rs_i | (uses_rt & EX.wreg == rt_i)).
  - rs is considered used by every opcode except j.
- EX-register load on each edge, in priority order:
  1. Reset.
  2. flush_i or stall_o or !valid_i or illegal → bubble.
  3. Otherwise → decoded bundle.
- MEM and WB registers always advance: MEM <= EX, WB <= MEM. No downstream stall exists.
- Latency: an instruction accepted at edge n is visible on ex_* after edge n, mem_* after n+1, and wb_* after n+2.
- A stalled instruction is re-presented by upstream and re-evaluated next cycle. The hazard clears after one bubble.
- flush_i and a hazard in the same cycle: flush wins, stall_o = 0, and a bubble is inserted.
- id_branch_o and id_jump_o are gated by valid_i & !stall_o & !flush_i.

Test Plan:
1. Reset low for 2 cycles with valid_i = 1, op = lw → all ex_/mem_/wb_ outputs and illegal_o are 0; stall_o = 0.
2. lw $2 at edge 0, then add rd=3, rs=2 presented → stall_o = 1 for one cycle, ex_alu_op_o = 000 with ex_wreg_o = 0 (bubble).
   - The next cycle, the add enters EX with ex_alu_op_o = 011, ex_wreg_o = 3.
   - wb_mem_to_reg_o = 1, wb_wreg_o = 2 two edges after the lw enters EX.
3. lw $0, then add rs=0 → stall_o = 0 (register-0 exemption), and the lw carries wb_reg_write_o = 0.
4. ori rt=5 with EX_OPS = 1 → ex_ext_op_o = 0, ex_alu_op_o = 101, wb_reg_write_o = 1, wb_wreg_o = 5.
   - With EXT_OPS = 0 → illegal_o pulses for one cycle, and a bubble is inserted.
5. beq with flush_i = 1, while lw $4 in EX and rs=4 → stall_o = 0, id_branch_o = 0, bubble in EX.
6. sw rt=7, with lw $7 in EX → stall_o = 1.
   - After resolution, mem_write_o = 1 at MEM, and wb_reg_write_o = 0.
